serial_fsub: RTL and testbench

//   Multi-cycle WIDTH-bit subtractor: diff = a - b - bi, borrow-out bo.

---
 rtl/serial_fsub.sv | 113 +++++++++++
 tb/tb_serial_fsub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fsub.sv
// Digit-serial subtractor: diff = a - b - bi over WIDTH/DIGIT clock steps, borrow-out bo.
// Valid/ready handshakes on both sides; one operation in flight at a time.
module serial_fsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
    $error("serial_fsub: WIDTH must be a non-zero multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             brw_q, bo_q, out_valid_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT:0]   step_d;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic             brw_d;
  logic [CW-1:0]    cnt_d;

  // One digit step: low digits subtract with the running borrow, result digit enters at the MSB end.
  always_comb begin
    step_d = '0;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    brw_d  = brw_q;
    cnt_d  = cnt_q;
    step_d = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT+1)'(brw_q);
    brw_d  = step_d[DIGIT];
    a_d    = a_q >> DIGIT;
    b_d    = b_q >> DIGIT;
    res_d  = (res_q >> DIGIT) | (WIDTH'(step_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    cnt_d  = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      brw_q       <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
      diff_q      <= '0;
      bo_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            brw_q   <= bi;
            res_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          a_q   <= a_d;
          b_q   <= b_d;
          brw_q <= brw_d;
          res_q <= res_d;
          cnt_q <= cnt_d;
          if (cnt_q == CW'(N - 1)) begin
            diff_q      <= res_d;
            bo_q        <= brw_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // diff/bo are held past the handshake; only out_valid drops.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so no operand is offered as accepted while reset is asserted.
  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_serial_fsub.sv
// Bench for serial_fsub: directed vector table, hand-written handshake/reset sequences,
// and randomized operations against an arithmetic reference for DIGIT = 4, 1 and 32.
module tb_serial_fsub;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         bi;
  logic [W-1:0] a, b;
  logic [1:0]   sel;

  logic [2:0]   iv, ordy, ir, ov, bov;
  logic [W-1:0] dv [3];

  logic         m_ov, m_ir, m_bo;
  logic [W-1:0] m_diff;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned DG = (k == 0) ? 4 : ((k == 1) ? 1 : 32);
    assign iv[k]   = in_valid  && (sel == k);
    assign ordy[k] = out_ready && (sel == k);
    serial_fsub #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .a         (a),
      .b         (b),
      .bi        (bi),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .diff      (dv[k]),
      .bo        (bov[k])
    );
  end

  always_comb begin
    m_ov   = ov[sel];
    m_ir   = ir[sel];
    m_bo   = bov[sel];
    m_diff = dv[sel];
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] diff;
    logic         bo;
  } vec_t;

  function automatic int nsteps(input logic [1:0] s);
    return (s == 2'd0) ? 8 : ((s == 2'd1) ? 32 : 1);
  endfunction

  // Reference: plain wide arithmetic; borrow is the unsigned "a < b + bi" test.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mbi);
    logic [W:0] wide;
    logic       mbo;
    wide = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbi);
    mbo  = ({1'b0, ma} < ({1'b0, mb} + (W+1)'(mbi)));
    return {mbo, wide[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!m_ir && k < 60) begin
      tick();
      k++;
    end
    chk({tag, " in_ready"}, W'(m_ir), W'(1));
  endtask

  task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi);
    a = xa; b = xb; bi = xbi; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bi = 1'($urandom_range(1));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xbi, input logic [W-1:0] ediff, input logic ebo);
    int lat;
    int k;
    logic r;
    wait_ready(tag);
    accept(xa, xb, xbi);
    lat = 0;
    while (!m_ov && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(nsteps(sel)));
    chk({tag, " diff"}, m_diff, ediff);
    chk({tag, " bo"}, W'(m_bo), W'(ebo));
    k = 0;
    do begin
      r = (k >= 20) ? 1'b1 : 1'($urandom_range(1));
      out_ready = r;
      tick();
      k++;
    end while (!r);
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, W'(m_ov), W'(0));
    chk({tag, " idle in_ready"}, W'(m_ir), W'(1));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt [7];
    logic [W:0]   ref_v;
    logic [W-1:0] hd, ra, rb;
    logic         hb, rbi;

    vt[0] = '{a: 32'd32,         b: 32'd34,         bi: 1'b0, diff: 32'hFFFF_FFFE, bo: 1'b1};
    vt[1] = '{a: 32'd65,         b: 32'd27,         bi: 1'b1, diff: 32'd37,        bo: 1'b0};
    vt[2] = '{a: 32'd0,          b: 32'd0,          bi: 1'b1, diff: 32'hFFFF_FFFF, bo: 1'b1};
    vt[3] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  bi: 1'b0, diff: 32'd0,         bo: 1'b0};
    vt[4] = '{a: 32'h8000_0000,  b: 32'd1,          bi: 1'b0, diff: 32'h7FFF_FFFF, bo: 1'b0};
    vt[5] = '{a: 32'd5,          b: 32'd5,          bi: 1'b1, diff: 32'hFFFF_FFFF, bo: 1'b1};
    vt[6] = '{a: 32'hFFFF_FFFF,  b: 32'd0,          bi: 1'b1, diff: 32'hFFFF_FFFE, bo: 1'b0};

    sel = 2'd0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bi = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("reset out_valid", W'(m_ov), W'(0));
    chk("reset diff", m_diff, W'(0));
    chk("reset bo", W'(m_bo), W'(0));
    chk("reset in_ready low", W'(m_ir), W'(0));
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", W'(m_ir), W'(1));

    // Directed vectors
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bi, vt[i].diff, vt[i].bo);

    // Back-pressure in DONE with an ignored in_valid pulse
    ref_v = model(32'h0000_1111, 32'h1234_5678, 1'b1);
    wait_ready("bp");
    accept(32'h0000_1111, 32'h1234_5678, 1'b1);
    for (int k = 0; k < 100 && !m_ov; k++) tick();
    hd = m_diff; hb = m_bo;
    chk("bp diff", hd, ref_v[W-1:0]);
    chk("bp bo", W'(hb), W'(ref_v[W]));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = 32'h5555_5555; b = 32'h1; bi = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      chk($sformatf("bp hold%0d out_valid", i), W'(m_ov), W'(1));
      chk($sformatf("bp hold%0d diff", i), m_diff, hd);
      chk($sformatf("bp hold%0d bo", i), W'(m_bo), W'(hb));
      chk($sformatf("bp hold%0d in_ready", i), W'(m_ir), W'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", W'(m_ov), W'(0));
    chk("bp release in_ready", W'(m_ir), W'(1));
    chk("bp diff kept", m_diff, hd);
    chk("bp bo kept", W'(m_bo), W'(hb));

    // Reset during CALC step 3
    wait_ready("rst");
    accept(32'hDEAD_0000, 32'd5, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst in_ready low", W'(m_ir), W'(0));
    tick();
    chk("rst out_valid", W'(m_ov), W'(0));
    chk("rst diff", m_diff, W'(0));
    chk("rst bo", W'(m_bo), W'(0));
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst release in_ready", W'(m_ir), W'(1));
    run_op("after rst", 32'd100, 32'd1, 1'b0, 32'd99, 1'b0);

    // Randomized operations for each DIGIT variant
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      for (int n = 0; n < 1000; n++) begin
        ra  = $urandom;
        rb  = $urandom;
        rbi = 1'($urandom_range(1));
        case ($urandom_range(7))
          0: ra = '0;
          1: rb = '1;
          2: rb = ra;
          default: ;
        endcase
        ref_v = model(ra, rb, rbi);
        run_op($sformatf("rnd s%0d n%0d", s, n), ra, rb, rbi, ref_v[W-1:0], ref_v[W]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
